// File: rtl/mastermind_scorer.sv
// Sequential Mastermind scorer: latches guess/answer, walks positions for exact
// matches, then walks colours for partial matches, and reports both counts.
module mastermind_scorer #(
    parameter int N_POS    = 4,
    parameter int COLOR_W  = 3,
    parameter int N_COLORS = 6
) (
    input  logic                     Clk,
    input  logic                     Reset_n,
    input  logic                     start,
    input  logic [N_POS*COLOR_W-1:0] guess,
    input  logic [N_POS*COLOR_W-1:0] answer,
    output logic                     busy,
    output logic                     done,
    output logic [2:0]               exact,
    output logic [2:0]               partial,
    output logic                     win,
    output logic [1:0]               dbg_state
);

    localparam int IW = (N_POS > 1) ? $clog2(N_POS) : 1;
    localparam int GW = N_POS * COLOR_W;
    localparam logic [IW-1:0]      LAST_IDX = IW'(N_POS - 1);
    localparam logic [COLOR_W-1:0] LAST_COL = COLOR_W'(N_COLORS);

    // Handshake: start is accepted only when busy is low (state IDLE and no
    // done pulse in progress); done pulses for one cycle with busy still high.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EXACT = 2'd1,
        COUNT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [GW-1:0]      g_q, g_d;
    logic [GW-1:0]      a_q, a_d;
    logic [N_POS-1:0]   m_q, m_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic [COLOR_W-1:0] col_q, col_d;
    logic [2:0]         ex_acc_q, ex_acc_d;
    logic [2:0]         pa_acc_q, pa_acc_d;
    logic [2:0]         exact_q, exact_d;
    logic [2:0]         partial_q, partial_d;
    logic               win_q, win_d;
    logic               done_q, done_d;

    logic [COLOR_W-1:0] g_peg, a_peg;
    logic [2:0]         gc, ac, min_c;
    logic               accept;

    assign g_peg  = g_q[int'(idx_q)*COLOR_W +: COLOR_W];
    assign a_peg  = a_q[int'(idx_q)*COLOR_W +: COLOR_W];
    assign accept = (state_q == IDLE) && !done_q && start;

    // Unmatched occurrences of the current colour in guess and answer.
    always_comb begin
        gc = 3'd0;
        ac = 3'd0;
        for (int j = 0; j < N_POS; j++) begin
            if (!m_q[j] && (g_q[j*COLOR_W +: COLOR_W] == col_q)) gc = gc + 3'd1;
            if (!m_q[j] && (a_q[j*COLOR_W +: COLOR_W] == col_q)) ac = ac + 3'd1;
        end
        min_c = (gc < ac) ? gc : ac;
    end

    always_comb begin
        state_d   = state_q;
        g_d       = g_q;
        a_d       = a_q;
        m_d       = m_q;
        idx_d     = idx_q;
        col_d     = col_q;
        ex_acc_d  = ex_acc_q;
        pa_acc_d  = pa_acc_q;
        exact_d   = exact_q;
        partial_d = partial_q;
        win_d     = win_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    g_d      = guess;
                    a_d      = answer;
                    m_d      = '0;
                    ex_acc_d = 3'd0;
                    pa_acc_d = 3'd0;
                    idx_d    = '0;
                    state_d  = EXACT;
                end
            end
            EXACT: begin
                if ((g_peg == a_peg) && (g_peg != '0)) begin
                    m_d[idx_q] = 1'b1;
                    ex_acc_d   = ex_acc_q + 3'd1;
                end
                idx_d = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    col_d   = COLOR_W'(1);
                    state_d = COUNT;
                end
            end
            COUNT: begin
                pa_acc_d = pa_acc_q + min_c;
                col_d    = col_q + 1'b1;
                if (col_q == LAST_COL) state_d = DONE;
            end
            DONE: begin
                exact_d   = ex_acc_q;
                partial_d = pa_acc_q;
                win_d     = (ex_acc_q == 3'(N_POS));
                done_d    = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= IDLE;
            g_q       <= '0;
            a_q       <= '0;
            m_q       <= '0;
            idx_q     <= '0;
            col_q     <= '0;
            ex_acc_q  <= 3'd0;
            pa_acc_q  <= 3'd0;
            exact_q   <= 3'd0;
            partial_q <= 3'd0;
            win_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            g_q       <= g_d;
            a_q       <= a_d;
            m_q       <= m_d;
            idx_q     <= idx_d;
            col_q     <= col_d;
            ex_acc_q  <= ex_acc_d;
            pa_acc_q  <= pa_acc_d;
            exact_q   <= exact_d;
            partial_q <= partial_d;
            win_q     <= win_d;
            done_q    <= done_d;
        end
    end

    assign busy      = (state_q != IDLE) || done_q;
    assign done      = done_q;
    assign exact     = exact_q;
    assign partial   = partial_q;
    assign win       = win_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_mastermind_scorer.sv
// Directed bench for mastermind_scorer: vector table plus hand-written
// sequences for busy-time restart, back-to-back starts and mid-run reset.
module tb_mastermind_scorer;

    localparam int GW = 12;

    logic          Clk = 1'b0;
    logic          Reset_n = 1'b0;
    logic          start = 1'b0;
    logic [GW-1:0] guess = '0;
    logic [GW-1:0] answer = '0;
    logic          busy, done, win;
    logic [2:0]    exact, partial;
    logic [1:0]    dbg_state;

    int n_tests = 0;
    int n_fail  = 0;

    mastermind_scorer dut (
        .Clk(Clk), .Reset_n(Reset_n), .start(start),
        .guess(guess), .answer(answer),
        .busy(busy), .done(done), .exact(exact), .partial(partial),
        .win(win), .dbg_state(dbg_state)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [GW-1:0] g;
        logic [GW-1:0] a;
        int            ex;
        int            pa;
        int            w;
    } vec_t;

    vec_t vecs[8];

    function automatic logic [GW-1:0] pk(input int p3, input int p2, input int p1, input int p0);
        return {3'(p3), 3'(p2), 3'(p1), 3'(p0)};
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Returns number of posedges until done is seen, or -1 after 40 edges.
    task automatic wait_done(output int cycles);
        bit seen;
        seen   = 1'b0;
        cycles = -1;
        for (int i = 1; i <= 40 && !seen; i++) begin
            @(posedge Clk);
            #1;
            if (done) begin
                seen   = 1'b1;
                cycles = i;
            end
        end
    endtask

    task automatic score(input vec_t v, input string tag);
        int c;
        @(negedge Clk);
        guess  = v.g;
        answer = v.a;
        start  = 1'b1;
        @(posedge Clk);
        #1;
        start = 1'b0;
        wait_done(c);
        check({tag, " latency"}, c, 11);
        check({tag, " exact"}, int'(exact), v.ex);
        check({tag, " partial"}, int'(partial), v.pa);
        check({tag, " win"}, int'(win), v.w);
        check({tag, " busy_at_done"}, int'(busy), 1);
        @(posedge Clk);
        #1;
        check({tag, " done_clear"}, int'(done), 0);
        check({tag, " busy_clear"}, int'(busy), 0);
    endtask

    initial begin
        int   c1, c2, ndone, cap_ex, cap_pa, cap_w;
        vec_t v;

        vecs[0] = '{pk(1,1,1,1), pk(1,1,1,1), 4, 0, 1};
        vecs[1] = '{pk(1,2,3,4), pk(4,3,2,1), 0, 4, 0};
        vecs[2] = '{pk(1,1,2,2), pk(1,2,1,2), 2, 2, 0};
        vecs[3] = '{pk(1,1,1,1), pk(4,3,2,1), 1, 0, 0};
        vecs[4] = '{pk(0,0,0,0), pk(1,1,1,1), 0, 0, 0};
        vecs[5] = '{pk(7,7,1,2), pk(7,7,2,1), 2, 2, 0};
        vecs[6] = '{pk(7,1,0,0), pk(1,7,0,0), 0, 1, 0};
        vecs[7] = '{pk(6,5,6,5), pk(5,6,5,6), 0, 4, 0};

        // Reset state
        repeat (2) @(posedge Clk);
        #1;
        check("rst busy", int'(busy), 0);
        check("rst done", int'(done), 0);
        check("rst exact", int'(exact), 0);
        check("rst partial", int'(partial), 0);
        check("rst win", int'(win), 0);
        check("rst state", int'(dbg_state), 0);
        @(negedge Clk);
        Reset_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            score(vecs[i], $sformatf("vec%0d", i));
        end

        // Results hold after done
        repeat (3) @(posedge Clk);
        #1;
        check("hold exact", int'(exact), 0);
        check("hold partial", int'(partial), 4);

        // Restart while busy is ignored; latched inputs are used
        @(negedge Clk);
        guess  = pk(1,2,3,4);
        answer = pk(1,2,3,4);
        start  = 1'b1;
        @(posedge Clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        guess  = pk(0,0,0,0);
        answer = pk(1,1,1,1);
        start  = 1'b1;
        @(negedge Clk);
        start  = 1'b0;
        ndone  = 0;
        cap_ex = -1;
        cap_pa = -1;
        cap_w  = -1;
        for (int i = 0; i < 25; i++) begin
            @(posedge Clk);
            #1;
            if (done) begin
                ndone++;
                cap_ex = int'(exact);
                cap_pa = int'(partial);
                cap_w  = int'(win);
            end
        end
        check("busy_restart ndone", ndone, 1);
        check("busy_restart exact", cap_ex, 4);
        check("busy_restart partial", cap_pa, 0);
        check("busy_restart win", cap_w, 1);

        // Start held high: back-to-back scoring
        @(negedge Clk);
        guess  = pk(1,2,3,4);
        answer = pk(4,3,2,1);
        start  = 1'b1;
        @(posedge Clk);
        #1;
        wait_done(c1);
        check("b2b first latency", c1, 11);
        wait_done(c2);
        start = 1'b0;
        check("b2b spacing", c2, 13);
        check("b2b exact", int'(exact), 0);
        check("b2b partial", int'(partial), 4);
        repeat (3) @(posedge Clk);
        #1;
        check("b2b idle", int'(busy), 0);

        // Run the win case so outputs are non-zero, then abort a run in COUNT
        v = vecs[0];
        score(v, "pre_abort");
        @(negedge Clk);
        guess  = pk(1,1,1,1);
        answer = pk(1,1,1,1);
        start  = 1'b1;
        @(posedge Clk);
        #1;
        start = 1'b0;
        repeat (7) @(posedge Clk);
        #1;
        check("abort in_count", int'(dbg_state), 2);
        #1;
        Reset_n = 1'b0;
        #1;
        check("abort exact", int'(exact), 0);
        check("abort partial", int'(partial), 0);
        check("abort win", int'(win), 0);
        check("abort busy", int'(busy), 0);
        check("abort done", int'(done), 0);
        @(negedge Clk);
        Reset_n = 1'b1;
        ndone   = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge Clk);
            #1;
            if (done) ndone++;
        end
        check("abort no_done", ndone, 0);
        score(vecs[2], "post_abort");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
